// File: rtl/axi_lite_master_param_if.sv
// AXI4-Lite bus bundle shared by the parametrised master and its slave/interconnect.
interface axi_lite_master_param_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master_param.sv
// Parametrised AXI4-Lite master: one-deep write/read request buffers, alternating
// arbitration when both are pending, independent AW/W handshakes, handshake timeout.
module axi_lite_master_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,   // 32 or 64
    parameter int TIMEOUT = 256   // 0 disables the timeout
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                wr_go,
    input  logic                rd_go,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    output logic                wr_done,
    output logic [1:0]          wr_resp,
    output logic                rd_done,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                busy,
    output logic                timeout_err,
    axi_lite_master_param_if.master axi
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_AW_W = 3'd1;
    localparam logic [2:0] WR_B    = 3'd2;
    localparam logic [2:0] RD_AR   = 3'd3;
    localparam logic [2:0] RD_R    = 3'd4;

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]          state;
    logic                wr_pend, rd_pend, pri_rd;
    logic [ADDR_W-1:0]   wa_buf, ra_buf, act_addr;
    logic [DATA_W-1:0]   wd_buf, act_data;
    logic [DATA_W/8-1:0] ws_buf, act_strb;
    logic                aw_done, w_done;
    logic [CNT_W-1:0]    cnt;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, tmo, pick_rd;

    // The active transaction is copied out of the buffer so a new go can refill
    // the buffer without disturbing the address/data on the bus.
    assign axi.awaddr  = act_addr;
    assign axi.araddr  = act_addr;
    assign axi.wdata   = act_data;
    assign axi.wstrb   = act_strb;
    assign axi.awvalid = (state == WR_AW_W) && !aw_done;
    assign axi.wvalid  = (state == WR_AW_W) && !w_done;
    assign axi.bready  = (state == WR_B);
    assign axi.arvalid = (state == RD_AR);
    assign axi.rready  = (state == RD_R);

    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign b_hs    = axi.bvalid && axi.bready;
    assign ar_hs   = axi.arvalid && axi.arready;
    assign r_hs    = axi.rvalid && axi.rready;
    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign tmo     = (TIMEOUT != 0) && (state != IDLE) && !any_hs && (cnt == CNT_LAST);
    assign pick_rd = rd_pend && (!wr_pend || pri_rd);
    assign busy    = (state != IDLE) || wr_pend || rd_pend;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            pri_rd      <= 1'b0;
            wa_buf      <= '0;
            ra_buf      <= '0;
            wd_buf      <= '0;
            ws_buf      <= '0;
            act_addr    <= '0;
            act_data    <= '0;
            act_strb    <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cnt         <= '0;
            wr_done     <= 1'b0;
            wr_resp     <= 2'b00;
            rd_done     <= 1'b0;
            rd_data     <= '0;
            rd_resp     <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= (state == IDLE || any_hs) ? '0 : cnt + 1'b1;

            if (wr_go && !wr_pend) begin
                wr_pend <= 1'b1;
                wa_buf  <= waddr;
                wd_buf  <= w_data;
                ws_buf  <= w_strb;
            end
            if (rd_go && !rd_pend) begin
                rd_pend <= 1'b1;
                ra_buf  <= raddr;
            end

            if (tmo) begin
                state       <= IDLE;
                timeout_err <= 1'b1;
                if (state == RD_AR || state == RD_R) begin
                    rd_done <= 1'b1;
                    rd_resp <= 2'b10;
                end else begin
                    wr_done <= 1'b1;
                    wr_resp <= 2'b10;
                end
            end else begin
                case (state)
                    IDLE: if (wr_pend || rd_pend) begin
                        if (wr_pend && rd_pend) pri_rd <= !pri_rd;
                        if (pick_rd) begin
                            state    <= RD_AR;
                            rd_pend  <= 1'b0;
                            act_addr <= ra_buf;
                        end else begin
                            state    <= WR_AW_W;
                            wr_pend  <= 1'b0;
                            act_addr <= wa_buf;
                            act_data <= wd_buf;
                            act_strb <= ws_buf;
                            aw_done  <= 1'b0;
                            w_done   <= 1'b0;
                        end
                    end
                    WR_AW_W: begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                        if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_B;
                    end
                    WR_B: if (b_hs) begin
                        wr_resp <= axi.bresp;
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end
                    RD_AR: if (ar_hs) state <= RD_R;
                    RD_R: if (r_hs) begin
                        rd_data <= axi.rdata;
                        rd_resp <= axi.rresp;
                        rd_done <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_param.sv
// Bench for axi_lite_master_param: channel-level transaction model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_axi_lite_master_param;
    localparam int TMO = 8;

    logic        aclk, areset, wr_go, rd_go;
    logic [31:0] waddr, raddr, w_data, rd_data;
    logic [3:0]  w_strb;
    logic        wr_done, rd_done, busy, timeout_err;
    logic [1:0]  wr_resp, rd_resp;

    axi_lite_master_param_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_lite_master_param #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .areset(areset), .wr_go(wr_go), .rd_go(rd_go),
        .waddr(waddr), .raddr(raddr), .w_data(w_data), .w_strb(w_strb),
        .wr_done(wr_done), .wr_resp(wr_resp), .rd_done(rd_done), .rd_data(rd_data),
        .rd_resp(rd_resp), .busy(busy), .timeout_err(timeout_err), .axi(axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors = 0, miscompares = 0, cyc = 0;

    // model: one-deep buffers per direction plus the transaction in flight,
    // described by which AXI channels it still needs
    bit          wbuf_v, rbuf_v, cur_v, cur_rd, need_aw, need_w, need_ar, pri_rd;
    logic [31:0] wbuf_addr, wbuf_data, rbuf_addr, cur_addr, cur_data;
    logic [3:0]  wbuf_strb, cur_strb;
    int          wait_n;
    bit          e_wr_done, e_rd_done, e_terr;
    logic [1:0]  e_wr_resp, e_rd_resp;
    logic [31:0] e_rd_data;

    // stimulus / observation
    bit          rnd = 0;
    int          thr = 10, aw_delay = -1, aw_hi = 0;
    int          aw_cnt, w_cnt, wr_dn, rd_dn, busy_low, first_wr_cyc, terr_wr, aw_chg, go_edge;
    bit          track_busy = 0;
    logic [31:0] aw_first, ar_seen;
    bit          order[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_awv(); return cur_v && !cur_rd && need_aw; endfunction
    function automatic bit m_wv();  return cur_v && !cur_rd && need_w;  endfunction
    function automatic bit m_br();  return cur_v && !cur_rd && !need_aw && !need_w; endfunction
    function automatic bit m_arv(); return cur_v && cur_rd && need_ar;  endfunction
    function automatic bit m_rr();  return cur_v && cur_rd && !need_ar; endfunction

    task automatic model_reset();
        wbuf_v = 0; rbuf_v = 0; cur_v = 0; cur_rd = 0; need_aw = 0; need_w = 0; need_ar = 0;
        pri_rd = 0; wait_n = 0; e_wr_done = 0; e_rd_done = 0; e_terr = 0;
        e_wr_resp = 0; e_rd_resp = 0; e_rd_data = 0;
    endtask

    task automatic model_step();
        bit wb, rb, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, take_rd;
        wb = wbuf_v; rb = rbuf_v;
        e_wr_done = 0; e_rd_done = 0; e_terr = 0;
        if (cur_v) begin
            aw_hs = m_awv() && axi.awready;
            w_hs  = m_wv()  && axi.wready;
            b_hs  = m_br()  && axi.bvalid;
            ar_hs = m_arv() && axi.arready;
            r_hs  = m_rr()  && axi.rvalid;
            any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
            if (!any_hs && wait_n + 1 == TMO) begin
                cur_v = 0; e_terr = 1;
                if (cur_rd) begin e_rd_done = 1; e_rd_resp = 2'b10; end
                else        begin e_wr_done = 1; e_wr_resp = 2'b10; end
            end else begin
                wait_n = any_hs ? 0 : wait_n + 1;
                if (aw_hs) need_aw = 0;
                if (w_hs)  need_w  = 0;
                if (ar_hs) need_ar = 0;
                if (b_hs) begin e_wr_done = 1; e_wr_resp = axi.bresp; cur_v = 0; end
                if (r_hs) begin e_rd_done = 1; e_rd_resp = axi.rresp; e_rd_data = axi.rdata; cur_v = 0; end
            end
        end else if (wb || rb) begin
            take_rd = rb && (!wb || pri_rd);
            if (wb && rb) pri_rd = !pri_rd;
            cur_v = 1; cur_rd = take_rd; wait_n = 0;
            if (take_rd) begin
                cur_addr = rbuf_addr; need_ar = 1; rbuf_v = 0;
            end else begin
                cur_addr = wbuf_addr; cur_data = wbuf_data; cur_strb = wbuf_strb;
                need_aw = 1; need_w = 1; wbuf_v = 0;
            end
        end
        if (wr_go && !wb) begin wbuf_v = 1; wbuf_addr = waddr; wbuf_data = w_data; wbuf_strb = w_strb; end
        if (rd_go && !rb) begin rbuf_v = 1; rbuf_addr = raddr; end
    endtask

    task automatic set_slave(input bit awr, input bit wr, input bit bv, input bit arr, input bit rv);
        axi.awready = awr; axi.wready = wr; axi.bvalid = bv; axi.arready = arr; axi.rvalid = rv;
    endtask

    task automatic reset_obs();
        aw_cnt = 0; w_cnt = 0; wr_dn = 0; rd_dn = 0; busy_low = 0; first_wr_cyc = -100;
        terr_wr = 0; aw_chg = 0; aw_first = 0; ar_seen = 0; order.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                                  busy, wr_done, rd_done, timeout_err, wr_resp, rd_resp}), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        check({tag, "_aw_w"}, {axi.awaddr, axi.wdata}, 64'd0);
        check({tag, "_ar_strb"}, 64'({axi.araddr, axi.wstrb}), 64'd0);
    endtask

    // one clock: compare in the low phase, drive slave, then advance the model
    task automatic cycle();
        check("awvalid", 64'(axi.awvalid), 64'(m_awv()));
        check("wvalid",  64'(axi.wvalid),  64'(m_wv()));
        check("bready",  64'(axi.bready),  64'(m_br()));
        check("arvalid", 64'(axi.arvalid), 64'(m_arv()));
        check("rready",  64'(axi.rready),  64'(m_rr()));
        if (m_awv()) check("awaddr", 64'(axi.awaddr), 64'(cur_addr));
        if (m_wv())  check("wdata_wstrb", 64'({axi.wdata, axi.wstrb}), 64'({cur_data, cur_strb}));
        if (m_arv()) check("araddr", 64'(axi.araddr), 64'(cur_addr));
        check("busy", 64'(busy), 64'(cur_v || wbuf_v || rbuf_v));
        check("done_terr", 64'({wr_done, rd_done, timeout_err}), 64'({e_wr_done, e_rd_done, e_terr}));
        check("resps", 64'({wr_resp, rd_resp}), 64'({e_wr_resp, e_rd_resp}));
        check("rd_data", 64'(rd_data), 64'(e_rd_data));

        if (axi.awvalid) begin
            if (aw_cnt == 0) aw_first = axi.awaddr;
            else if (axi.awaddr !== aw_first) aw_chg++;
            aw_cnt++;
        end
        if (axi.wvalid) w_cnt++;
        if (axi.arvalid) ar_seen = axi.araddr;
        if (wr_done) begin
            if (wr_dn == 0) first_wr_cyc = cyc;
            wr_dn++; order.push_back(1'b0);
            if (timeout_err) terr_wr++;
        end
        if (rd_done) begin rd_dn++; order.push_back(1'b1); end
        if (track_busy && (wr_dn + rd_dn) < 2 && !busy) busy_low++;

        if (rnd) begin
            wr_go = ($urandom_range(0, 5) == 0); rd_go = ($urandom_range(0, 5) == 0);
            waddr = $urandom; w_data = $urandom; w_strb = 4'($urandom_range(0, 15)); raddr = $urandom;
            set_slave($urandom_range(0, 9) < thr, $urandom_range(0, 9) < thr, $urandom_range(0, 9) < thr,
                      $urandom_range(0, 9) < thr, $urandom_range(0, 9) < thr);
            axi.bresp = 2'($urandom_range(0, 3)); axi.rresp = 2'($urandom_range(0, 3)); axi.rdata = $urandom;
        end else if (aw_delay >= 0) begin
            axi.awready = (aw_hi >= aw_delay);
        end
        aw_hi = axi.awvalid ? aw_hi + 1 : 0;

        @(posedge aclk);
        cyc++;
        model_step();
        @(negedge aclk);
    endtask

    initial begin
        areset = 1; wr_go = 0; rd_go = 0; waddr = 0; raddr = 0; w_data = 0; w_strb = 0;
        set_slave(0, 0, 0, 0, 0); axi.bresp = 0; axi.rresp = 0; axi.rdata = 0;
        model_reset();
        repeat (2) @(negedge aclk);
        check_zero("reset");
        areset = 0;

        // single write, everything ready
        set_slave(1, 1, 1, 1, 1); reset_obs();
        waddr = 32'hAABBAABB; w_data = 32'hDADADADA; w_strb = 4'hF; wr_go = 1;
        go_edge = cyc + 1; cycle(); wr_go = 0;
        repeat (8) cycle();
        check("t1_latency", 64'(first_wr_cyc - go_edge), 64'd3);
        check("t1_aw_cycles", 64'(aw_cnt), 64'd1);
        check("t1_w_cycles", 64'(w_cnt), 64'd1);
        check("t1_done_resp", 64'({wr_dn, wr_resp}), 64'({32'd1, 2'b00}));

        // awready held off 4 cycles, wready immediate, BRESP passed through
        set_slave(0, 1, 1, 1, 1); axi.bresp = 2'b01; aw_delay = 4; aw_hi = 0; reset_obs();
        waddr = 32'h00000040; w_data = 32'h11223344; w_strb = 4'h5; wr_go = 1;
        cycle(); wr_go = 0;
        repeat (12) cycle();
        aw_delay = -1;
        check("t2_aw_cycles", 64'(aw_cnt), 64'd5);
        check("t2_w_cycles", 64'(w_cnt), 64'd1);
        check("t2_awaddr_stable", 64'(aw_chg), 64'd0);
        check("t2_done_resp", 64'({wr_dn, wr_resp}), 64'({32'd1, 2'b01}));

        // read with SLVERR response
        set_slave(1, 1, 1, 1, 1); axi.bresp = 0; axi.rdata = 32'h12345678; axi.rresp = 2'b10; reset_obs();
        raddr = 32'h00001000; rd_go = 1;
        cycle(); rd_go = 0;
        repeat (8) cycle();
        check("t3_araddr", 64'(ar_seen), 64'h1000);
        check("t3_rd", 64'({rd_dn, rd_data, rd_resp}), 64'({16'd1, 32'h12345678, 2'b10}));

        // simultaneous gos twice: W,R then R,W
        axi.rresp = 0;
        for (int p = 0; p < 2; p++) begin
            reset_obs();
            waddr = 32'h100 + p; w_data = 32'hA0 + p; w_strb = 4'hF; raddr = 32'h200 + p;
            wr_go = 1; rd_go = 1; cycle(); wr_go = 0; rd_go = 0;
            track_busy = 1; repeat (14) cycle(); track_busy = 0;
            check("t4_ndone", 64'(order.size()), 64'd2);
            check("t4_order", 64'(order.size() >= 2 ? {order[0], order[1]} : 2'bxx), (p == 0) ? 64'b01 : 64'b10);
            check("t4_busy_low", 64'(busy_low), 64'd0);
        end

        // AW and W never accepted: abort after TMO cycles
        set_slave(0, 0, 1, 1, 1); reset_obs();
        waddr = 32'hDEAD0000; w_data = 32'h5; w_strb = 4'h1; wr_go = 1;
        cycle(); wr_go = 0;
        repeat (14) cycle();
        check("t5_aw_cycles", 64'(aw_cnt), 64'd8);
        check("t5_w_cycles", 64'(w_cnt), 64'd8);
        check("t5_done_terr", 64'({wr_dn, terr_wr}), 64'({32'd1, 32'd1}));
        check("t5_resp_idle", 64'({wr_resp, busy}), 64'({2'b10, 1'b0}));

        // reset while waiting in the B phase, then a clean read
        set_slave(1, 1, 0, 1, 1); reset_obs();
        waddr = 32'h300; w_data = 32'h77; w_strb = 4'hF; wr_go = 1;
        cycle(); wr_go = 0;
        repeat (3) cycle();
        check("t6_in_b_phase", 64'(axi.bready), 64'd1);
        #2 areset = 1;
        #1 check_zero("t6_reset");
        model_reset();
        @(negedge aclk); areset = 0;
        set_slave(1, 1, 1, 1, 1); axi.rdata = 32'hCAFEF00D; axi.rresp = 0; reset_obs();
        raddr = 32'h2000; rd_go = 1;
        cycle(); rd_go = 0;
        repeat (8) cycle();
        check("t6_read", 64'({rd_dn, rd_data, rd_resp}), 64'({16'd1, 32'hCAFEF00D, 2'b00}));

        // randomized traffic with varying slave stall rates and occasional reset
        rnd = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: thr = 10;
                    1: thr = 6;
                    default: thr = 2;
                endcase
            end
            cycle();
            if (i % 1000 == 999) begin
                #2 areset = 1;
                #1 check_zero("rnd_reset");
                model_reset();
                @(negedge aclk); areset = 0;
            end
        end
        rnd = 0; wr_go = 0; rd_go = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
